// File: rtl/input_1943_pkg.sv
// Shared definitions for the 1943 cabinet input conditioner.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none; inputs are sampled levels with no flow control.
package input_1943_pkg;

  // Joystick bit layout, identical for both players
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_t;

  // Opposite directions pressed together cancel to "neither pressed".
  // Fire bits are passed through untouched.
  function automatic logic [5:0] joy_clean(input logic [5:0] d);
    logic [5:0] o;
    o = d;
    if (!d[JOY_RIGHT] && !d[JOY_LEFT]) begin
      o[JOY_RIGHT] = 1'b1;
      o[JOY_LEFT]  = 1'b1;
    end
    if (!d[JOY_UP] && !d[JOY_DOWN]) begin
      o[JOY_UP]   = 1'b1;
      o[JOY_DOWN] = 1'b1;
    end
    return o;
  endfunction

endpackage

// File: rtl/input_cond_1943_coin_shaper.sv
// Turns debounced coin falling edges into fixed-width low pulses with a guaranteed gap.
// Latency: coin_n falls 1 cycle after the first tick on which IDLE sees a queued coin.
// Backpressure: up to 3 coins queue; an edge arriving with a full queue is dropped and flagged.
module coin_shaper #(
  parameter int COIN_LEN = 8,
  parameter int COIN_GAP = 8
) (
  input  logic bus_clk,
  input  logic bus_rst,
  input  logic i_tick,
  input  logic i_deb,
  output logic o_coin_n,
  output logic o_coin_drop
);
  import input_1943_pkg::*;

  coin_state_t r_state;
  coin_state_t w_state_nxt;
  logic [7:0]  r_tc;
  logic [7:0]  w_tc_nxt;
  logic [1:0]  r_pend;
  logic        r_prev;
  logic        r_coin_n;
  logic        w_coin_n_nxt;
  logic        r_drop;
  logic        w_deq;
  logic        w_fall;

  // A coin drop is the debounced level going 1 -> 0
  assign w_fall = r_prev & ~i_deb;

  // Next-state logic for the pulse/gap sequencer; all timing advances on ticks only
  always_comb begin
    w_state_nxt  = r_state;
    w_tc_nxt     = r_tc;
    w_coin_n_nxt = r_coin_n;
    w_deq        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_tick && (r_pend != 2'd0)) begin
          w_state_nxt  = PULSE;
          w_tc_nxt     = 8'd0;
          w_coin_n_nxt = 1'b0;
          w_deq        = 1'b1;
        end
      end
      PULSE: begin
        if (i_tick) begin
          if (r_tc + 8'd1 == 8'(COIN_LEN)) begin
            w_state_nxt  = GAP;
            w_tc_nxt     = 8'd0;
            w_coin_n_nxt = 1'b1;
          end else begin
            w_tc_nxt = r_tc + 8'd1;
          end
        end
      end
      GAP: begin
        if (i_tick) begin
          if (r_tc + 8'd1 == 8'(COIN_GAP)) begin
            w_state_nxt = IDLE;
            w_tc_nxt    = 8'd0;
          end else begin
            w_tc_nxt = r_tc + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_tc_nxt     = 8'd0;
        w_coin_n_nxt = 1'b1;
      end
    endcase
  end

  // Sequencer state register; reset forces coin_n high immediately
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_state  <= IDLE;
      r_tc     <= 8'd0;
      r_coin_n <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tc     <= w_tc_nxt;
      r_coin_n <= w_coin_n_nxt;
    end
  end

  // Pending-coin queue: a simultaneous edge and dequeue cancel, so that edge is never lost
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_pend <= 2'd0;
      r_prev <= 1'b1;
      r_drop <= 1'b0;
    end else begin
      r_prev <= i_deb;
      r_drop <= w_fall & ~w_deq & (r_pend == 2'd3);
      if (w_fall && !w_deq) begin
        if (r_pend != 2'd3) r_pend <= r_pend + 2'd1;
      end else if (!w_fall && w_deq) begin
        r_pend <= r_pend - 2'd1;
      end
    end
  end

  assign o_coin_n    = r_coin_n;
  assign o_coin_drop = r_drop;

endmodule

// File: rtl/input_cond_1943.sv
// Synchronises, debounces and cleans the 1943 cabinet inputs; shapes coin drops into pulses.
// Latency: 2 sync + DEB_TICKS ticks to the debounced state, +1 registered output.
// Backpressure: none on levels; coin edges queue 3 deep per slot, overflow pulses coin_drop.
module input_cond_1943 #(
  parameter int TICK_DIV  = 72000,
  parameter int DEB_TICKS = 4,
  parameter int COIN_LEN  = 8,
  parameter int COIN_GAP  = 8
) (
  input  logic       bus_rst,
  input  logic       bus_clk,
  input  logic [1:0] raw_start_n,
  input  logic [1:0] raw_coin_n,
  input  logic [5:0] raw_joy1_n,
  input  logic [5:0] raw_joy2_n,
  output logic [1:0] start_n,
  output logic [1:0] coin_n,
  output logic [5:0] joy1_n,
  output logic [5:0] joy2_n,
  output logic [1:0] coin_drop
);
  import input_1943_pkg::*;

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Packed view of all inputs: [1:0] start, [3:2] coin, [9:4] joy1, [15:10] joy2
  logic [15:0]      w_raw;
  logic [15:0]      r_sync1;
  logic [15:0]      r_sync2;
  logic [15:0]      r_deb;
  logic [3:0]       r_cnt [16];
  logic [PRE_W-1:0] r_pre;
  logic             w_tick;
  logic [1:0]       r_start_n;
  logic [5:0]       r_joy1_n;
  logic [5:0]       r_joy2_n;

  assign w_raw  = {raw_joy2_n, raw_joy1_n, raw_coin_n, raw_start_n};
  assign w_tick = (r_pre == PRE_W'(TICK_DIV - 1));

  // Two-flop synchroniser on every raw bit; idles at the released (high) level
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Millisecond prescaler; tick is the last count before wrap
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Per-bit debounce: DEB_TICKS consecutive differing ticks flip the state
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_deb <= '1;
      for (int i = 0; i < 16; i++) r_cnt[i] <= 4'd0;
    end else if (w_tick) begin
      for (int i = 0; i < 16; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] + 4'd1 == 4'(DEB_TICKS)) begin
            r_deb[i] <= ~r_deb[i];
            r_cnt[i] <= 4'd0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 4'd1;
          end
        end else begin
          r_cnt[i] <= 4'd0;
        end
      end
    end
  end

  // Registered start and cleaned joystick outputs
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_start_n <= '1;
      r_joy1_n  <= '1;
      r_joy2_n  <= '1;
    end else begin
      r_start_n <= r_deb[1:0];
      r_joy1_n  <= joy_clean(r_deb[9:4]);
      r_joy2_n  <= joy_clean(r_deb[15:10]);
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_coin
    coin_shaper #(
      .COIN_LEN (COIN_LEN),
      .COIN_GAP (COIN_GAP)
    ) u_coin_shaper (
      .bus_clk     (bus_clk),
      .bus_rst     (bus_rst),
      .i_tick      (w_tick),
      .i_deb       (r_deb[2+s]),
      .o_coin_n    (coin_n[s]),
      .o_coin_drop (coin_drop[s])
    );
  end

  assign start_n = r_start_n;
  assign joy1_n  = r_joy1_n;
  assign joy2_n  = r_joy2_n;

endmodule

// File: tb/tb_input_cond_1943.sv
// Bench for input_cond_1943: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
// Small parameters keep the tick period at 4 cycles.
module tb_input_cond_1943;

  localparam int TD  = 4;
  localparam int DEB = 2;
  localparam int LEN = 3;
  localparam int GAP = 2;

  logic       bus_clk;
  logic       bus_rst;
  logic [1:0] raw_start_n;
  logic [1:0] raw_coin_n;
  logic [5:0] raw_joy1_n;
  logic [5:0] raw_joy2_n;
  logic [1:0] start_n;
  logic [1:0] coin_n;
  logic [5:0] joy1_n;
  logic [5:0] joy2_n;
  logic [1:0] coin_drop;

  input_cond_1943 #(
    .TICK_DIV  (TD),
    .DEB_TICKS (DEB),
    .COIN_LEN  (LEN),
    .COIN_GAP  (GAP)
  ) dut (
    .bus_rst     (bus_rst),
    .bus_clk     (bus_clk),
    .raw_start_n (raw_start_n),
    .raw_coin_n  (raw_coin_n),
    .raw_joy1_n  (raw_joy1_n),
    .raw_joy2_n  (raw_joy2_n),
    .start_n     (start_n),
    .coin_n      (coin_n),
    .joy1_n      (joy1_n),
    .joy2_n      (joy2_n),
    .coin_drop   (coin_drop)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Ticks fall on every TD-th clock edge after reset; a debounced bit flips when
  // the last DEB tick samples all disagree with it; coin pulses are scheduled by timestamps.
  int          m_n;
  logic [15:0] m_s1, m_s2, m_deb, m_deb_prev;
  logic [15:0] m_hist [$];
  logic [1:0]  m_start, m_coin, m_drop;
  logic [5:0]  m_joy1, m_joy2;
  int          m_pend    [2];
  int          m_start_at[2];
  int          m_next_ok [2];

  function automatic logic [5:0] m_clean(input logic [5:0] d);
    logic rl, ud;
    rl = (d[1:0] == 2'b00);
    ud = (d[3:2] == 2'b00);
    return d | {2'b00, ud, ud, rl, rl};
  endfunction

  always @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      m_n = 0;
      m_s1 = '1; m_s2 = '1; m_deb = '1; m_deb_prev = '1;
      m_hist.delete();
      m_start = '1; m_coin = '1; m_drop = '0; m_joy1 = '1; m_joy2 = '1;
      for (int s = 0; s < 2; s++) begin
        m_pend[s] = 0; m_start_at[s] = -1000; m_next_ok[s] = 0;
      end
    end else begin
      logic        tick, fall, deq, flip;
      logic [15:0] old_deb;
      m_n++;
      tick = ((m_n % TD) == 0);
      old_deb = m_deb;
      for (int s = 0; s < 2; s++) begin
        fall = m_deb_prev[2+s] & ~old_deb[2+s];
        deq  = tick && (m_n >= m_next_ok[s]) && (m_pend[s] > 0);
        m_drop[s] = fall && !deq && (m_pend[s] == 3);
        if (deq) begin
          m_start_at[s] = m_n;
          m_next_ok[s]  = m_n + (LEN + GAP) * TD + 1;
        end
        if (fall && !deq && m_pend[s] < 3) m_pend[s]++;
        else if (!fall && deq) m_pend[s]--;
        m_coin[s] = !((m_n >= m_start_at[s]) && (m_n < m_start_at[s] + LEN * TD));
      end
      m_start = old_deb[1:0];
      m_joy1  = m_clean(old_deb[9:4]);
      m_joy2  = m_clean(old_deb[15:10]);
      if (tick) begin
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
          for (int b = 0; b < 16; b++) begin
            flip = 1'b1;
            foreach (m_hist[k]) if (m_hist[k][b] == old_deb[b]) flip = 1'b0;
            if (flip) m_deb[b] = ~old_deb[b];
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = {raw_joy2_n, raw_joy1_n, raw_coin_n, raw_start_n};
      m_deb_prev = old_deb;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge bus_clk) begin
    chk("start_n",   16'(start_n),   16'(m_start));
    chk("coin_n",    16'(coin_n),    16'(m_coin));
    chk("joy1_n",    16'(joy1_n),    16'(m_joy1));
    chk("joy2_n",    16'(joy2_n),    16'(m_joy2));
    chk("coin_drop", 16'(coin_drop), 16'(m_drop));
  end

  // ---------------- pulse-shape monitor ----------------
  int mon_low  [2];
  int mon_high [2];
  int mon_seen [2];
  int mon_pulses[2];
  int mon_drops [2];

  initial begin
    for (int s = 0; s < 2; s++) begin
      mon_low[s] = 0; mon_high[s] = 0; mon_seen[s] = 0; mon_pulses[s] = 0; mon_drops[s] = 0;
    end
  end

  always @(negedge bus_clk) begin
    for (int s = 0; s < 2; s++) begin
      if (bus_rst) begin
        mon_low[s] = 0; mon_high[s] = 0; mon_seen[s] = 0;
      end else begin
        if (coin_n[s] === 1'b0) begin
          if (mon_low[s] == 0 && mon_seen[s] != 0) begin
            n_vec++;
            if (mon_high[s] < GAP * TD + 1) begin
              n_bad++;
              $display("FAIL coin_gap[%0d]: got %0d cycles, need >= %0d", s, mon_high[s], GAP * TD + 1);
            end
          end
          mon_low[s]++;
        end else begin
          if (mon_low[s] > 0) begin
            chk("coin_low_len", 16'(mon_low[s]), 16'(LEN * TD));
            mon_pulses[s]++;
            mon_seen[s] = 1;
            mon_high[s] = 0;
            mon_low[s]  = 0;
          end
          mon_high[s]++;
        end
        if (coin_drop[s] === 1'b1) mon_drops[s]++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge bus_clk);
  endtask

  initial begin
    int p0, p1, d1, k;
    bus_rst = 1'b1;
    raw_start_n = '1; raw_coin_n = '1; raw_joy1_n = '1; raw_joy2_n = '1;
    cyc(3);
    chk("reset_outs", {start_n, coin_n, joy1_n, joy2_n}, 16'hFFFF);
    chk("reset_drop", 16'(coin_drop), 16'h0000);
    bus_rst = 1'b0;

    // 1: idle after reset
    cyc(100);
    chk("idle_outs", {start_n, coin_n, joy1_n, joy2_n}, 16'hFFFF);
    chk("idle_drop", 16'(coin_drop), 16'h0000);

    // 2: short glitch ignored, sustained press accepted
    raw_joy1_n[4] = 1'b0;
    cyc(3);
    raw_joy1_n[4] = 1'b1;
    cyc(20);
    chk("glitch_fire1", 16'(joy1_n[4]), 16'h0001);
    raw_joy1_n[4] = 1'b0;
    k = 0;
    while (joy1_n[4] !== 1'b0 && k < 14) begin
      cyc(1);
      k++;
    end
    chk("deb_fire1_fall", 16'(joy1_n[4]), 16'h0000);
    cyc(20);
    chk("deb_fire1_hold", 16'(joy1_n), 16'h002F);
    raw_joy1_n[4] = 1'b1;
    raw_start_n = 2'b10;
    cyc(20);
    chk("start_press", 16'(start_n), 16'h0002);
    raw_start_n = 2'b11;

    // 3: opposite directions cancel
    raw_joy2_n[1:0] = 2'b00;
    cyc(20);
    chk("joy2_rl_cancel", 16'(joy2_n), 16'h003F);
    raw_joy2_n[1:0] = 2'b10;
    cyc(20);
    chk("joy2_right_only", 16'(joy2_n[1:0]), 16'h0002);
    raw_joy2_n = 6'b110000;
    cyc(20);
    chk("joy2_ud_rl_cancel", 16'(joy2_n), 16'h003F);
    raw_joy2_n = 6'b111011;
    cyc(20);
    chk("joy2_down_only", 16'(joy2_n), 16'h003B);
    raw_joy2_n = '1;
    cyc(20);

    // 4: one held coin gives one pulse
    p0 = mon_pulses[0];
    raw_coin_n[0] = 1'b0;
    cyc(200);
    raw_coin_n[0] = 1'b1;
    cyc(80);
    chk("single_coin_pulses", 16'(mon_pulses[0] - p0), 16'h0001);
    chk("single_coin_idle", 16'(coin_n), 16'h0003);

    // 5: rapid drops on slot 1 overflow the 3-deep queue
    p1 = mon_pulses[1];
    d1 = mon_drops[1];
    for (int e = 0; e < 16; e++) begin
      raw_coin_n[1] = 1'b0;
      cyc(8);
      raw_coin_n[1] = 1'b1;
      cyc(8);
    end
    cyc(200);
    chk("queue_accounting", 16'((mon_pulses[1] - p1) + (mon_drops[1] - d1)), 16'd16);
    n_vec++;
    if (mon_drops[1] - d1 < 1) begin
      n_bad++;
      $display("FAIL queue_drops: got %0d drops, need >= 1", mon_drops[1] - d1);
    end
    chk("queue_idle", 16'(coin_n), 16'h0003);

    // 6: reset in the middle of a pulse
    raw_coin_n[0] = 1'b0;
    k = 0;
    while (coin_n[0] !== 1'b0 && k < 40) begin
      cyc(1);
      k++;
    end
    chk("rst_pulse_started", 16'(coin_n[0]), 16'h0000);
    p0 = mon_pulses[0];
    cyc(3);
    #2 bus_rst = 1'b1;
    #1 chk("rst_async_coin", 16'(coin_n[0]), 16'h0001);
    raw_coin_n[0] = 1'b1;
    cyc(3);
    bus_rst = 1'b0;
    cyc(80);
    chk("rst_no_pulse", 16'(mon_pulses[0] - p0), 16'h0000);
    chk("rst_final_outs", {start_n, coin_n, joy1_n, joy2_n}, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
